// File: rtl/sat_counter_table.sv
// sat_counter_table
//   Pattern history table of 2^INDEX_BITS saturating counters with two
//   combinational read ports and one update port. After reset or flush the
//   table re-initialises itself by walking every entry, one per cycle.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous, active-high; restarts the init walk
//   flush      synchronous request to re-initialise the whole table
//   ready      high when the table is usable (READY state)
//   rd1_index  read port 1 index    -> rd1_count / rd1_taken (MSB of count)
//   rd2_index  read port 2 index    -> rd2_count / rd2_taken (MSB of count)
//   upd_valid  update strobe
//   upd_index  entry to update
//   upd_taken  resolved outcome: 1 = increment, 0 = decrement (saturating)
module sat_counter_table #(
  parameter int CTR_BITS   = 2,
  parameter int INDEX_BITS = 5,
  parameter int INIT_VALUE = 1,
  parameter bit BYPASS     = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  output logic                  ready,
  input  logic [INDEX_BITS-1:0] rd1_index,
  output logic [CTR_BITS-1:0]   rd1_count,
  output logic                  rd1_taken,
  input  logic [INDEX_BITS-1:0] rd2_index,
  output logic [CTR_BITS-1:0]   rd2_count,
  output logic                  rd2_taken,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken
);

  localparam int                    DEPTH      = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0]   INIT_CTR   = CTR_BITS'(INIT_VALUE);
  localparam logic [CTR_BITS-1:0]   CTR_MAX    = {CTR_BITS{1'b1}};
  localparam logic [INDEX_BITS-1:0] LAST_INDEX = {INDEX_BITS{1'b1}};

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [INDEX_BITS-1:0] init_ptr_reg, init_ptr_next;

  // Counter storage; deliberately not reset, the init walk clears it.
  logic [CTR_BITS-1:0]   table_mem [DEPTH];

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= INIT;
      init_ptr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_ptr_reg <= init_ptr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_ptr_next = init_ptr_reg;
    case (state_reg)
      INIT: begin
        if (flush) begin
          init_ptr_next = '0;
        end else begin
          init_ptr_next = init_ptr_reg + INDEX_BITS'(1);
          // Last entry is written this cycle, so the table is usable next.
          if (init_ptr_reg == LAST_INDEX) begin
            state_next = READY;
          end
        end
      end
      READY: begin
        if (flush) begin
          state_next    = INIT;
          init_ptr_next = '0;
        end
      end
      default: begin
        state_next    = INIT;
        init_ptr_next = '0;
      end
    endcase
  end

  assign ready = (state_reg == READY);

  // ---------------------------------------------------------------------
  // Update path: flush takes priority and updates are ignored while walking
  // ---------------------------------------------------------------------
  logic                upd_en;
  logic [CTR_BITS-1:0] upd_old;
  logic [CTR_BITS-1:0] upd_new;

  assign upd_en  = (state_reg == READY) && upd_valid && !flush;
  assign upd_old = table_mem[upd_index];

  always_comb begin
    upd_new = upd_old;
    if (upd_taken) begin
      if (upd_old != CTR_MAX) begin
        upd_new = upd_old + CTR_BITS'(1);
      end
    end else begin
      if (upd_old != '0) begin
        upd_new = upd_old - CTR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_reg == INIT) begin
      table_mem[init_ptr_reg] <= INIT_CTR;
    end else if (upd_en) begin
      table_mem[upd_index] <= upd_new;
    end
  end

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  logic [INDEX_BITS-1:0] rd_index [2];
  logic [CTR_BITS-1:0]   rd_count [2];

  assign rd_index[0] = rd1_index;
  assign rd_index[1] = rd2_index;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic hit;
    assign hit = BYPASS && upd_en && (rd_index[gi] == upd_index);
    // While walking, the array content is partly stale: report INIT_VALUE.
    assign rd_count[gi] = (state_reg == INIT) ? INIT_CTR :
                          hit                 ? upd_new  :
                                                table_mem[rd_index[gi]];
  end

  assign rd1_count = rd_count[0];
  assign rd1_taken = rd_count[0][CTR_BITS-1];
  assign rd2_count = rd_count[1];
  assign rd2_taken = rd_count[1][CTR_BITS-1];

endmodule

// File: tb/tb_sat_counter_table.sv
// tb_sat_counter_table
//   Directed bench for sat_counter_table. Two instances share the stimulus:
//   dut0 with BYPASS=0 and dut1 with BYPASS=1. Expected values are pushed to
//   a scoreboard queue when stimulus is applied and popped when sampled.
module tb_sat_counter_table;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [4:0] rd1_index;
  logic [4:0] rd2_index;
  logic       upd_valid;
  logic [4:0] upd_index;
  logic       upd_taken;

  logic       ready_0, ready_1;
  logic [1:0] rd1_count_0, rd2_count_0, rd1_count_1, rd2_count_1;
  logic       rd1_taken_0, rd2_taken_0, rd1_taken_1, rd2_taken_1;

  always #5 clk = ~clk;

  sat_counter_table #(
    .CTR_BITS  (2),
    .INDEX_BITS(5),
    .INIT_VALUE(1),
    .BYPASS    (1'b0)
  ) dut0 (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .ready    (ready_0),
    .rd1_index(rd1_index),
    .rd1_count(rd1_count_0),
    .rd1_taken(rd1_taken_0),
    .rd2_index(rd2_index),
    .rd2_count(rd2_count_0),
    .rd2_taken(rd2_taken_0),
    .upd_valid(upd_valid),
    .upd_index(upd_index),
    .upd_taken(upd_taken)
  );

  sat_counter_table #(
    .CTR_BITS  (2),
    .INDEX_BITS(5),
    .INIT_VALUE(1),
    .BYPASS    (1'b1)
  ) dut1 (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .ready    (ready_1),
    .rd1_index(rd1_index),
    .rd1_count(rd1_count_1),
    .rd1_taken(rd1_taken_1),
    .rd2_index(rd2_index),
    .rd2_count(rd2_count_1),
    .rd2_taken(rd2_taken_1),
    .upd_valid(upd_valid),
    .upd_index(upd_index),
    .upd_taken(upd_taken)
  );

  // Observed {taken, count} per instance/port.
  int o01, o02, o11, o12;
  assign o01 = {29'd0, rd1_taken_0, rd1_count_0};
  assign o02 = {29'd0, rd2_taken_0, rd2_count_0};
  assign o11 = {29'd0, rd1_taken_1, rd1_count_1};
  assign o12 = {29'd0, rd2_taken_1, rd2_count_1};

  typedef struct {
    string tag;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   model [32];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected {taken, count} for a counter value.
  function automatic int pack(input int c);
    return {29'd0, c[1], c[1:0]};
  endfunction

  function automatic int sat_next(input int c, input logic taken);
    if (taken) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  task automatic push(input string tag, input int e);
    sb.push_back('{tag: tag, exp: e});
  endtask

  task automatic pop_check(input int obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty observed=%0d required=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%0d required=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < 32; i++) model[i] = 1;
  endtask

  // One update transaction with both read ports on the same index.
  // Call between edges; returns 2 time units after the update edge.
  task automatic do_update(input int idx, input logic taken);
    int oldv;
    int newv;
    oldv      = model[idx];
    newv      = sat_next(oldv, taken);
    upd_valid = 1'b1;
    upd_index = 5'(idx);
    upd_taken = taken;
    rd1_index = 5'(idx);
    rd2_index = 5'(idx);
    push($sformatf("same_cycle_d0p1_i%0d", idx), pack(oldv));
    push($sformatf("same_cycle_d0p2_i%0d", idx), pack(oldv));
    push($sformatf("bypass_d1p1_i%0d", idx), pack(newv));
    push($sformatf("bypass_d1p2_i%0d", idx), pack(newv));
    #1;
    pop_check(o01);
    pop_check(o02);
    pop_check(o11);
    pop_check(o12);
    @(posedge clk);
    #1;
    upd_valid  = 1'b0;
    model[idx] = newv;
    push($sformatf("after_edge_d0p1_i%0d", idx), pack(newv));
    push($sformatf("after_edge_d0p2_i%0d", idx), pack(newv));
    push($sformatf("after_edge_d1p1_i%0d", idx), pack(newv));
    #1;
    pop_check(o01);
    pop_check(o02);
    pop_check(o11);
    $display("upd idx=%0d taken=%0b old=%0d new=%0d", idx, taken, oldv, newv);
  endtask

  // Count edges until ready rises (bounded). Optionally issues a dropped
  // update at edge drop_at and checks INIT reads at edge ro_at.
  task automatic wait_ready(input string tag, input int drop_at, input int ro_at);
    int edges;
    edges = 0;
    while (ready_0 !== 1'b1 && edges < 64) begin
      @(posedge clk);
      #1;
      edges++;
      upd_valid = 1'b0;
      if (edges == drop_at) begin
        upd_valid = 1'b1;
        upd_index = 5'd3;
        upd_taken = 1'b1;
      end
      if (edges == ro_at) begin
        rd1_index = 5'd17;
        rd2_index = 5'd30;
        push({tag, "_init_read_d0p1"}, pack(1));
        push({tag, "_init_read_d1p2"}, pack(1));
        #1;
        pop_check(o01);
        pop_check(o12);
      end
    end
    upd_valid = 1'b0;
    push({tag, "_edges_to_ready"}, 32);
    push({tag, "_ready_d1"}, 1);
    pop_check(edges);
    pop_check({31'd0, ready_1});
    $display("walk %s ready after %0d edges", tag, edges);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    rd1_index = '0;
    rd2_index = '0;
    upd_valid = 1'b0;
    upd_index = '0;
    upd_taken = 1'b0;
    model_init();

    // Reset state
    #1;
    push("reset_ready_d0", 0);
    push("reset_ready_d1", 0);
    push("reset_read_d0p1", pack(1));
    pop_check({31'd0, ready_0});
    pop_check({31'd0, ready_1});
    pop_check(o01);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_ready("walk_reset", -1, 3);

    // Every entry reads the init value on both ports
    for (int i = 0; i < 32; i++) begin
      rd1_index = 5'(i);
      rd2_index = 5'(31 - i);
      push($sformatf("sweep_d0p1_i%0d", i), pack(model[i]));
      push($sformatf("sweep_d1p2_i%0d", 31 - i), pack(model[31 - i]));
      #1;
      pop_check(o01);
      pop_check(o12);
    end
    $display("sweep after reset walk done");

    @(posedge clk);
    #1;

    // Saturation up then down on entry 5
    repeat (4) do_update(5, 1'b1);
    repeat (5) do_update(5, 1'b0);

    // Bypass on entry 9
    do_update(9, 1'b1);

    // Flush priority over a same-cycle update of entry 3
    do_update(3, 1'b1);
    do_update(3, 1'b1);
    flush     = 1'b1;
    upd_valid = 1'b1;
    upd_index = 5'd3;
    upd_taken = 1'b0;
    rd1_index = 5'd3;
    rd2_index = 5'd3;
    push("flush_cycle_d0p1", pack(3));
    push("flush_cycle_no_bypass_d1p1", pack(3));
    #1;
    pop_check(o01);
    pop_check(o11);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    upd_valid = 1'b0;
    push("flush_ready_d0", 0);
    push("flush_ready_d1", 0);
    push("flush_init_read_d1p1", pack(1));
    #1;
    pop_check({31'd0, ready_0});
    pop_check({31'd0, ready_1});
    pop_check(o11);
    $display("flush issued with update idx=3 taken=0");
    model_init();
    wait_ready("walk_flush", 5, -1);
    rd1_index = 5'd3;
    rd2_index = 5'd9;
    push("post_flush_d0p1_i3", pack(model[3]));
    push("post_flush_d1p1_i3", pack(model[3]));
    push("post_flush_d0p2_i9", pack(model[9]));
    #1;
    pop_check(o01);
    pop_check(o11);
    pop_check(o02);

    // Dirty an entry, then asynchronous reset while READY
    do_update(7, 1'b1);
    reset = 1'b1;
    push("async_reset_ready_d0", 0);
    push("async_reset_ready_d1", 0);
    #1;
    pop_check({31'd0, ready_0});
    pop_check({31'd0, ready_1});
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_init();

    // Asynchronous reset at walk cycle 10, between edges
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    push("abort_ready_d0", 0);
    #1;
    pop_check({31'd0, ready_0});
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("walk aborted by reset at cycle 10");
    wait_ready("walk_after_abort", -1, -1);
    rd1_index = 5'd7;
    rd2_index = 5'd7;
    push("post_reset_d0p1_i7", pack(model[7]));
    push("post_reset_d1p2_i7", pack(model[7]));
    #1;
    pop_check(o01);
    pop_check(o12);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sat_counter_table.md
Name: sat_counter_table

Overview:
Parametrised pattern history table: 2^INDEX_BITS saturating counters of CTR_BITS each, with two combinational read ports and one update port. It sits in the fetch/branch-predict path. Fetch reads a prediction through both ports; the resolving stage sends taken/not-taken outcomes. The table does the increment/decrement and saturation itself. On reset or flush it re-initialises through a sequential walk.

Parameters:
CTR_BITS, 2, width of each saturating counter (>=1)
INDEX_BITS, 5, index width; depth = 2^INDEX_BITS entries
INIT_VALUE, 1, value written to every entry on init (must be < 2^CTR_BITS; 1 = weakly not-taken for CTR_BITS=2)
BYPASS, 0, 1 = read ports forward the same-cycle update result; 0 = read ports return the stored value

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
flush  in  1  synchronous request to re-initialise the whole table
ready  out  1  high when the table is usable (READY state)
rd1_index  in  INDEX_BITS  read port 1 index
rd1_count  out  CTR_BITS  counter value, port 1
rd1_taken  out  1  prediction, port 1 (MSB of rd1_count)
rd2_index  in  INDEX_BITS  read port 2 index
rd2_count  out  CTR_BITS  counter value, port 2
rd2_taken  out  1  prediction, port 2 (MSB of rd2_count)
upd_valid  in  1  update strobe
upd_index  in  INDEX_BITS  entry to update
upd_taken  in  1  resolved outcome: 1 = increment, 0 = decrement

Behaviour:
- The interface uses one clock, clk. reset is asynchronous and active-high.
- FSM states: INIT and READY.
- Reset asserted: state=INIT, init_ptr=0, ready=0, immediately (asynchronous). The storage array itself is not asynchronously reset; it is cleared by the walk.
- INIT state:
  - Each cycle: entry[init_ptr] <= INIT_VALUE, then init_ptr++.
  - When init_ptr = 2^INDEX_BITS-1 is written: next state READY, ready=1. The walk takes exactly 2^INDEX_BITS cycles after reset deassertion.
- Reads during INIT: rdN_count = INIT_VALUE and rdN_taken = INIT_VALUE[CTR_BITS-1], regardless of index.
- Updates during INIT are dropped with no effect.
- READY + flush: next state INIT, init_ptr=0, ready=0 from the next cycle. Any same-cycle upd_valid is dropped (flush wins).
- flush during INIT: restarts the walk with init_ptr=0.
- Reset during INIT or READY: aborts everything and restarts the walk.
- Update (READY, upd_valid=1, flush=0), written at the rising edge:
  - upd_taken=1: new = min(old+1, 2^CTR_BITS-1).
  - upd_taken=0: new = max(old-1, 0).
  - Saturation is mandatory; no wrap-around at either boundary.
- Reads are combinational from the array.
  - BYPASS=0: the value written at edge k is visible on the read ports after edge k.
  - BYPASS=1: if upd_valid, READY, !flush and rdN_index==upd_index, rdN_count shows the post-update value in the same cycle.
- Both read ports are independent; the same index on both ports returns identical data.
- rdN_taken is always the MSB of rdN_count, including under bypass.

Test Plan:
- Walk timing: reset pulse, then idle 32 cycles (defaults) -> ready rises exactly on the 32nd edge after reset falls; every index reads count=1, taken=0.
- Saturation up: index 5, upd_taken=1 for 4 consecutive cycles -> count sequence 2,3,3,3; taken=1 from the value 2 onward.
- Saturation down: index 5 from 3, upd_taken=0 for 5 cycles -> 2,1,0,0,0; taken=0 from the value 1 onward.
- Bypass: BYPASS=1 with entry 9=1, upd index 9 taken=1, rd1_index=9, rd2_index=9 in the same cycle -> both ports show 2/taken=1 combinationally. BYPASS=0 -> both show 1 that cycle and 2 next cycle.
- Flush priority: entry 3=3, assert flush and upd(3,taken=0) together -> ready=0 next cycle; after 32 cycles entry 3 reads 1 (not 2). An update issued during the walk has no effect.
- Async reset mid-walk: assert reset at walk cycle 10 between clock edges -> ready=0 and init_ptr=0 immediately; after release, the full 32-cycle walk completes before ready=1.
